// File: rtl/keypad_pkg.sv
// Shared constants, press-latch state type and one-hot/BCD helpers for the keypad front end.
package keypad_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam int unsigned DIGIT_W  = 4;

    typedef enum logic {
        LATCH_ARMED,
        LATCH_HELD
    } latch_state_t;

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (v[k]) ones++;
        end
        return (ones == 1);
    endfunction

    // Returns 4'hF for anything that is not exactly one key.
    function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] v);
        logic [DIGIT_W-1:0] d;
        d = '1;
        if (is_onehot(v)) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (v[k]) d = DIGIT_W'(k);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Two-flop synchroniser followed by a stability counter; db follows the synchronised
// vector only after it has held still for DEBOUNCE_CYCLES cycles.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned WIDTH           = NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] db
);

    localparam int unsigned       CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt;

    // sync1 != sync2 means sync2 is about to change, so the count restarts with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cnt   <= '0;
            db    <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync1 != sync2) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                db <= sync2;
            end
        end
    end

endmodule

// File: rtl/keypad.sv
// Keypad front end: debounced one-hot buttons become BCD digits shifted into a
// NUM_DIGITS-deep register, with a one-cycle pulse per accepted press.
module keypad
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned NUM_DIGITS      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_KEYS-1:0]           keypad_buttons,
    input  logic                          keypad_reset_shift,
    output logic [DIGIT_W*NUM_DIGITS-1:0] keypad_values,
    output logic                          shift_pulse
);

    localparam int unsigned VAL_W = DIGIT_W * NUM_DIGITS;

    logic [NUM_KEYS-1:0] db;
    logic                accept;
    logic [DIGIT_W-1:0]  digit;
    latch_state_t        latch_state;

    keypad_debounce #(
        .WIDTH           (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (keypad_buttons),
        .db    (db)
    );

    always_comb begin
        accept = 1'b0;
        digit  = onehot_to_bcd(db);
        if ((latch_state == LATCH_ARMED) && is_onehot(db)) begin
            accept = 1'b1;
        end
    end

    // Any non-zero db consumes the armed latch, including multi-key and cleared presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_state   <= LATCH_ARMED;
            keypad_values <= '0;
            shift_pulse   <= 1'b0;
        end else begin
            latch_state <= (db == '0) ? LATCH_ARMED : LATCH_HELD;
            shift_pulse <= accept && !keypad_reset_shift;
            if (keypad_reset_shift) begin
                keypad_values <= '0;
            end else if (accept) begin
                keypad_values <= {keypad_values[VAL_W-DIGIT_W-1:0], digit};
            end
        end
    end

endmodule

// File: tb/tb_keypad.sv
// Directed and randomized checks of keypad against a sample-history reference model.
module tb_keypad;

    localparam int unsigned D = 2;

    logic        clk;
    logic        rst_n;
    logic [9:0]  keypad_buttons;
    logic        keypad_reset_shift;
    logic [15:0] keypad_values;
    logic        shift_pulse;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned obs_pulses;
    int unsigned cyc;
    int unsigned last_pulse_cyc;

    // Reference model state: raw samples taken at each edge, debounced view, outputs.
    logic [9:0]  hist[$];
    logic [9:0]  m_db;
    logic [9:0]  m_db_prev;
    logic [15:0] m_vals;
    logic        m_pulse;

    keypad #(
        .DEBOUNCE_CYCLES (D),
        .NUM_DIGITS      (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .keypad_buttons     (keypad_buttons),
        .keypad_reset_shift (keypad_reset_shift),
        .keypad_values      (keypad_values),
        .shift_pulse        (shift_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (D + 2) hist.push_back(10'd0);
        m_db      = '0;
        m_db_prev = '0;
        m_vals    = '0;
        m_pulse   = 1'b0;
    endtask

    // A key counts when the debounced view leaves all-released for exactly one key.
    // The debounced view adopts a raw value once D+1 consecutive samples agree.
    task automatic model_edge(input logic [9:0] b, input logic rs);
        logic [3:0] dg;
        bit         stable;
        dg = 4'd0;
        for (int k = 0; k < 10; k++) if (m_db[k]) dg = 4'(k);
        m_pulse = (m_db_prev == 10'd0) && ($countones(m_db) == 1) && !rs;
        if (rs)           m_vals = 16'h0000;
        else if (m_pulse) m_vals = {m_vals[11:0], dg};
        m_db_prev = m_db;
        stable = 1'b1;
        for (int i = 0; i <= int'(D); i++) begin
            if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) stable = 1'b0;
        end
        if (stable) m_db = hist[hist.size() - 1];
        hist.push_back(b);
        void'(hist.pop_front());
    endtask

    task automatic cycle(input logic [9:0] b, input logic rs);
        @(negedge clk);
        keypad_buttons     = b;
        keypad_reset_shift = rs;
        @(posedge clk);
        model_edge(b, rs);
        #1;
        cyc++;
        chk("values", {16'd0, keypad_values}, {16'd0, m_vals});
        chk("pulse", {31'd0, shift_pulse}, {31'd0, m_pulse});
        if (shift_pulse) begin
            obs_pulses++;
            last_pulse_cyc = cyc;
        end
    endtask

    task automatic hold(input logic [9:0] b, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(b, 1'b0);
    endtask

    task automatic press(input int unsigned d);
        logic [9:0] oh;
        oh = 10'd1 << d;
        hold(oh, D + 5);
        hold(10'd0, D + 5);
    endtask

    initial begin
        logic [15:0]  clr_exp[4];
        logic [9:0]   cur;
        logic         rs;
        int unsigned  p0;
        int unsigned  start_cyc;

        n_cmp = 0; n_err = 0; obs_pulses = 0; cyc = 0; last_pulse_cyc = 0;
        clr_exp = '{16'h0006, 16'h0067, 16'h0678, 16'h6789};
        rst_n = 1'b0;
        keypad_buttons = '0;
        keypad_reset_shift = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", {16'd0, keypad_values}, 32'h0);
        chk("reset_pulse", {31'd0, shift_pulse}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Digit sequence 0..9,0 with latency measured on the first press.
        p0 = obs_pulses;
        start_cyc = cyc;
        press(0);
        chk("latency", last_pulse_cyc - start_cyc, D + 3);
        for (int unsigned i = 1; i <= 9; i++) begin
            press(i);
            if (i == 2) chk("seq_after3", {16'd0, keypad_values}, 32'h0012);
            if (i == 9) chk("seq_after9", {16'd0, keypad_values}, 32'h6789);
        end
        press(0);
        chk("seq_final", {16'd0, keypad_values}, 32'h7890);
        chk("seq_pulses", obs_pulses - p0, 11);

        // Clear, then refill.
        cycle(10'd0, 1'b1);
        cycle(10'd0, 1'b0);
        chk("clear_values", {16'd0, keypad_values}, 32'h0);
        for (int unsigned i = 0; i < 4; i++) begin
            press(6 + i);
            chk("refill", {16'd0, keypad_values}, {16'd0, clr_exp[i]});
        end

        // Bouncing key 5 settles into a single press.
        p0 = obs_pulses;
        cycle(10'h020, 1'b0); cycle(10'h000, 1'b0); cycle(10'h020, 1'b0);
        cycle(10'h000, 1'b0); cycle(10'h020, 1'b0);
        hold(10'h020, D + 5);
        hold(10'h000, D + 5);
        chk("bounce_pulses", obs_pulses - p0, 1);
        chk("bounce_values", {16'd0, keypad_values}, 32'h7895);
        p0 = obs_pulses;
        cycle(10'h020, 1'b0);
        hold(10'h000, D + 5);
        chk("glitch_pulses", obs_pulses - p0, 0);

        // Multi-key rejection and lock-out while held.
        p0 = obs_pulses;
        hold(10'h003, D + 5);
        hold(10'h000, D + 5);
        chk("multi_pulses", obs_pulses - p0, 0);
        hold(10'h001, D + 5);
        hold(10'h003, D + 5);
        hold(10'h000, D + 5);
        chk("hold_add_pulses", obs_pulses - p0, 1);
        chk("hold_add_values", {16'd0, keypad_values}, 32'h8950);

        // Clear coinciding with the accept edge swallows the press.
        p0 = obs_pulses;
        hold(10'h010, D + 2);
        cycle(10'h010, 1'b1);
        chk("collide_values", {16'd0, keypad_values}, 32'h0);
        chk("collide_pulse", {31'd0, shift_pulse}, 32'h0);
        hold(10'h010, 4);
        hold(10'h000, D + 5);
        chk("collide_pulses", obs_pulses - p0, 0);
        press(3);
        chk("after_collide", {16'd0, keypad_values}, 32'h0003);

        // Asynchronous reset mid-operation.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_values", {16'd0, keypad_values}, 32'h0);
        chk("async_reset_pulse", {31'd0, shift_pulse}, 32'h0);
        keypad_buttons = '0;
        keypad_reset_shift = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        cur = '0;
        for (int unsigned i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    cur = '0;
                    2, 3, 4: cur = 10'd1 << $urandom_range(0, 9);
                    default: cur = 10'($urandom);
                endcase
            end
            rs = ($urandom_range(0, 29) == 0);
            cycle(cur, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
